// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and the MDU.
// Holds ALU operation codes, R-type funct codes, aluOp class codes,
// the MDU FSM state encodings and a helper that classifies MDU functs.
package alu_control_mdu_pkg;

  // ALU operation codes driven to the main ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // R-type funct codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  // aluOp instruction classes
  localparam logic [1:0] AOP_MEM   = 2'b00;
  localparam logic [1:0] AOP_BEQ   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;

  // MDU FSM states
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DIV  = 2'b10;
  localparam logic [1:0] S_FIX  = 2'b11;

  // True for every funct that touches the MDU or HI/LO
  function automatic logic is_mdu_funct(input logic [5:0] funct);
    logic r;
    case (funct)
      F_MULT, F_MULTU, F_DIV, F_DIVU,
      F_MFHI, F_MTHI, F_MFLO, F_MTLO: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_control_mdu_iter.sv
// mdu_iter: iterative multiply/divide engine, one bit per cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i aborts;
//   start_i/is_div_i/is_signed_i/a_i/b_i launch an op (honoured in IDLE);
//   busy_o high in MUL/DIV/FIX; done_o high in FIX with hi_o/lo_o valid.
module mdu_iter
  import alu_control_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d, state_nx_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic               div_q, div_d, neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;

  logic               sgn_a_s, sgn_b_s;
  logic [WIDTH-1:0]   a_abs_s, b_abs_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] prod_s;

  assign sgn_a_s = is_signed_i & a_i[WIDTH-1];
  assign sgn_b_s = is_signed_i & b_i[WIDTH-1];
  assign a_abs_s = sgn_a_s ? -a_i : a_i;
  assign b_abs_s = sgn_b_s ? -b_i : b_i;

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum_s = {1'b0, acc_hi_q} + ({1'b0, opb_q} & {(WIDTH+1){acc_lo_q[0]}});

  // Restoring divide: shift in the next dividend bit and subtract the divisor when it fits.
  // When it fits the true difference is below 2**WIDTH, so the low WIDTH bits are exact.
  assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opb_q});
  assign div_diff_s  = div_shift_s[WIDTH-1:0] - opb_q;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIX);
  assign state_d = flush_i ? S_IDLE : state_nx_s;

  // Next-state and datapath step for launch, iteration and fix-up
  always_comb begin
    state_nx_s = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    div_d      = div_q;
    neg_hi_d   = neg_hi_q;
    neg_lo_d   = neg_lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_nx_s = is_div_i ? S_DIV : S_MUL;
          cnt_d      = {CNT_W{1'b0}};
          acc_hi_d   = {WIDTH{1'b0}};
          acc_lo_d   = is_div_i ? a_abs_s : b_abs_s;
          opb_d      = is_div_i ? b_abs_s : a_abs_s;
          div_d      = is_div_i;
          // Divide by zero keeps the all-ones quotient unnegated.
          neg_lo_d   = (sgn_a_s ^ sgn_b_s) & (~is_div_i | (|b_i));
          neg_hi_d   = is_div_i & sgn_a_s;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_MUL: begin
        acc_hi_d = mul_sum_s[WIDTH:1];
        acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_nx_s = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DIV: begin
        acc_hi_d = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_s};
        if (cnt_q == CNT_LAST) begin
          state_nx_s = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIX:   state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Sign fix-up: the product is negated as a whole, quotient and remainder independently
  always_comb begin
    prod_s = {acc_hi_q, acc_lo_q};
    if (div_q) begin
      hi_o = neg_hi_q ? -acc_hi_q : acc_hi_q;
      lo_o = neg_lo_q ? -acc_lo_q : acc_lo_q;
    end else begin
      {hi_o, lo_o} = neg_lo_q ? -prod_s : prod_s;
    end
  end

  // State, counter and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      div_q    <= div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: EX-stage ALU control decoder with an iterative MDU and HI/LO.
// Ports: clk/rst_n clock and async active-low reset; valid_i/flush_i pipeline
//   control; aluOp/functionField decode inputs; rs_val/rt_val operands;
//   operation ALU op (comb); stall_o hold EX (comb); busy_o MDU iterating;
//   mdu_rd_o MFHI/MFLO data (comb); hi_o/lo_o architectural HI/LO.
module alu_control_mdu
  import alu_control_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       functionField,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [OP_W-1:0]  operation,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] mdu_rd_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [3:0]       op_s;
  logic             rtype_s, mdu_fn_s, muldiv_fn_s, accept_s, start_s;
  logic             busy_s, done_s;
  logic [WIDTH-1:0] iter_hi_s, iter_lo_s;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // ALU operation decode, independent of valid_i
  always_comb begin
    op_s = ALU_AND;
    case (aluOp)
      AOP_MEM: op_s = ALU_ADD;
      AOP_BEQ: op_s = ALU_SUB;
      AOP_RTYPE: begin
        case (functionField)
          F_ADD, F_ADDU: op_s = ALU_ADD;
          F_SUB, F_SUBU: op_s = ALU_SUB;
          F_AND:         op_s = ALU_AND;
          F_OR:          op_s = ALU_OR;
          F_XOR:         op_s = ALU_XOR;
          F_NOR:         op_s = ALU_NOR;
          F_SLT:         op_s = ALU_SLT;
          F_SLTU:        op_s = ALU_SLTU;
          F_SLL:         op_s = ALU_SLL;
          F_SRL:         op_s = ALU_SRL;
          F_SRA:         op_s = ALU_SRA;
          default:       op_s = ALU_AND;
        endcase
      end
      default: op_s = ALU_AND;
    endcase
  end

  assign operation = OP_W'(op_s);

  assign rtype_s     = (aluOp == AOP_RTYPE);
  assign mdu_fn_s    = rtype_s & is_mdu_funct(functionField);
  // MULT/MULTU/DIV/DIVU share prefix 0110; bit1 selects divide, bit0 selects unsigned.
  assign muldiv_fn_s = rtype_s & (functionField[5:2] == 4'b0110);
  assign stall_o     = valid_i & busy_s & mdu_fn_s;
  assign accept_s    = valid_i & ~stall_o & ~flush_i;
  assign start_s     = accept_s & muldiv_fn_s;
  assign busy_o      = busy_s;

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mdu_iter (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush_i),
    .start_i     (start_s),
    .is_div_i    (functionField[1]),
    .is_signed_i (~functionField[0]),
    .a_i         (rs_val),
    .b_i         (rt_val),
    .busy_o      (busy_s),
    .done_o      (done_s),
    .hi_o        (iter_hi_s),
    .lo_o        (iter_lo_s)
  );

  // HI/LO next value: MDU result, else MTHI/MTLO; a flush suppresses both
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (done_s && !flush_i) begin
      hi_d = iter_hi_s;
      lo_d = iter_lo_s;
    end else if (accept_s && rtype_s) begin
      case (functionField)
        F_MTHI:  hi_d = rs_val;
        F_MTLO:  lo_d = rs_val;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // MFHI/MFLO read port
  always_comb begin
    mdu_rd_o = {WIDTH{1'b0}};
    if (rtype_s) begin
      case (functionField)
        F_MFHI:  mdu_rd_o = hi_q;
        F_MFLO:  mdu_rd_o = lo_q;
        default: mdu_rd_o = {WIDTH{1'b0}};
      endcase
    end else begin
      mdu_rd_o = {WIDTH{1'b0}};
    end
  end

  // Architectural HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= {WIDTH{1'b0}};
      lo_q <= {WIDTH{1'b0}};
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed self-checking bench for alu_control_mdu (WIDTH=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_control_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  aluOp = 2'b00;
  logic [5:0]  functionField = 6'b000000;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [3:0]  operation;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] mdu_rd_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad = 0;
  int n;
  int m;
  logic [31:0] lo_early;

  alu_control_mdu #(.WIDTH(32), .OP_W(4), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .aluOp(aluOp), .functionField(functionField), .rs_val(rs_val), .rt_val(rt_val),
    .operation(operation), .stall_o(stall_o), .busy_o(busy_o), .mdu_rd_o(mdu_rd_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one valid R-type instruction for a single cycle (called on a falling edge)
  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; aluOp = 2'b10; functionField = fn; rs_val = a; rt_val = b;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_o === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_timeout", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic dec_chk(input logic [1:0] aop, input logic [5:0] fn, input logic [3:0] exp);
    aluOp = aop; functionField = fn;
    #1;
    check_eq($sformatf("dec_%b_%b", aop, fn), {60'd0, operation}, {60'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    valid_i = 1'b1; aluOp = 2'b10; functionField = 6'b010000;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
    check_eq("rst_hi", {32'd0, hi_o}, 64'd0);
    check_eq("rst_lo", {32'd0, lo_o}, 64'd0);
    check_eq("rst_rd", {32'd0, mdu_rd_o}, 64'd0);
    valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Reset mid-op
    issue(6'b010011, 32'h55, 32'd0);
    check_eq("t1_mtlo", {32'd0, lo_o}, 64'h55);
    issue(6'b011000, 32'd7, 32'd9);
    check_eq("t1_busy", {63'd0, busy_o}, 64'd1);
    repeat (4) @(negedge clk);
    check_eq("t1_busy_t5", {63'd0, busy_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t1_rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("t1_rst_hi", {32'd0, hi_o}, 64'd0);
    check_eq("t1_rst_lo", {32'd0, lo_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    valid_i = 1'b1; aluOp = 2'b10; functionField = 6'b010010;
    #1;
    check_eq("t1_mflo", {32'd0, mdu_rd_o}, 64'd0);
    check_eq("t1_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    valid_i = 1'b0;

    // 2. MULT -3 * 5, latency
    issue(6'b011000, 32'hFFFFFFFD, 32'd5);
    n = 0;
    for (int k = 1; k <= 33; k++) begin
      if (busy_o === 1'b1) n++;
      if (k == 33) lo_early = lo_o;
      @(negedge clk);
    end
    check_eq("t2_busy_cycles", 64'(n), 64'd33);
    check_eq("t2_lo_early", {32'd0, lo_early}, 64'd0);
    check_eq("t2_busy_end", {63'd0, busy_o}, 64'd0);
    check_eq("t2_hi", {32'd0, hi_o}, 64'hFFFFFFFF);
    check_eq("t2_lo", {32'd0, lo_o}, 64'hFFFFFFF1);

    // 3. DIV -7 / 2 followed by a stalled MFLO
    issue(6'b011010, 32'hFFFFFFF9, 32'd2);
    valid_i = 1'b1; aluOp = 2'b10; functionField = 6'b010010;
    n = 0; m = 0;
    while (busy_o === 1'b1 && m < 100) begin
      if (stall_o === 1'b1) n++;
      m++;
      @(negedge clk);
    end
    check_eq("t3_stall_cycles", 64'(n), 64'd33);
    check_eq("t3_stall_end", {63'd0, stall_o}, 64'd0);
    check_eq("t3_mflo", {32'd0, mdu_rd_o}, 64'hFFFFFFFD);
    check_eq("t3_hi", {32'd0, hi_o}, 64'hFFFFFFFF);
    valid_i = 1'b0;

    // 4. Divide corner cases and more products
    issue(6'b011011, 32'd10, 32'd0); wait_idle();
    check_eq("t4_divu0", {hi_o, lo_o}, 64'h0000000A_FFFFFFFF);
    issue(6'b011010, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    check_eq("t4_ovf", {hi_o, lo_o}, 64'h00000000_80000000);
    issue(6'b011010, 32'd7, 32'hFFFFFFFE); wait_idle();
    check_eq("t4_div_7_m2", {hi_o, lo_o}, 64'h00000001_FFFFFFFD);
    issue(6'b011010, 32'hFFFFFFF8, 32'd0); wait_idle();
    check_eq("t4_div_m8_0", {hi_o, lo_o}, 64'hFFFFFFF8_FFFFFFFF);
    issue(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle();
    check_eq("t4_multu_max", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
    issue(6'b011000, 32'd7, 32'd9); wait_idle();
    check_eq("t4_mult_7_9", {hi_o, lo_o}, 64'h00000000_0000003F);

    // 5. Flush aborts an op in flight; flush beats start and MT*
    issue(6'b010001, 32'h1234, 32'd0);
    issue(6'b010011, 32'h5678, 32'd0);
    check_eq("t5_mthi", {32'd0, hi_o}, 64'h1234);
    issue(6'b011001, 32'hFFFFFFFF, 32'd2);
    repeat (9) @(negedge clk);
    check_eq("t5_busy_t10", {63'd0, busy_o}, 64'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("t5_busy_t11", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk);
    check_eq("t5_hilo_kept", {hi_o, lo_o}, 64'h00001234_00005678);
    valid_i = 1'b1; aluOp = 2'b10; functionField = 6'b011000; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    check_eq("t5_flush_start", {63'd0, busy_o}, 64'd0);
    valid_i = 1'b1; functionField = 6'b010001; rs_val = 32'h9999; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    check_eq("t5_flush_mthi", {32'd0, hi_o}, 64'h1234);

    // 6. Decode sweep
    dec_chk(2'b00, 6'b100010, 4'b0010);
    dec_chk(2'b01, 6'b100000, 4'b0110);
    dec_chk(2'b11, 6'b100000, 4'b0000);
    dec_chk(2'b10, 6'b100000, 4'b0010);
    dec_chk(2'b10, 6'b100001, 4'b0010);
    dec_chk(2'b10, 6'b100010, 4'b0110);
    dec_chk(2'b10, 6'b100011, 4'b0110);
    dec_chk(2'b10, 6'b100100, 4'b0000);
    dec_chk(2'b10, 6'b100101, 4'b0001);
    dec_chk(2'b10, 6'b100110, 4'b0011);
    dec_chk(2'b10, 6'b100111, 4'b1100);
    dec_chk(2'b10, 6'b101010, 4'b0111);
    dec_chk(2'b10, 6'b101011, 4'b1000);
    dec_chk(2'b10, 6'b000000, 4'b1001);
    dec_chk(2'b10, 6'b000010, 4'b1010);
    dec_chk(2'b10, 6'b000011, 4'b1011);
    dec_chk(2'b10, 6'b111111, 4'b0000);
    dec_chk(2'b10, 6'b011000, 4'b0000);

    // Non-MDU op while busy does not stall; MDU op does
    @(negedge clk);
    issue(6'b011000, 32'd1, 32'd1);
    valid_i = 1'b1; aluOp = 2'b10; functionField = 6'b100000;
    #1;
    check_eq("t6_add_busy_stall", {63'd0, stall_o}, 64'd0);
    functionField = 6'b010000;
    #1;
    check_eq("t6_mfhi_busy_stall", {63'd0, stall_o}, 64'd1);
    valid_i = 1'b0;
    wait_idle();
    check_eq("t6_mult_1_1", {hi_o, lo_o}, 64'h00000000_00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
